// File: rtl/axis_pair_adder.sv
// Mesh compute node: pairs consecutive AXI-Stream operands and emits their
// wrapped sum as a single-beat packet addressed to the output node.
module axis_pair_adder #(
  parameter int TDATAW   = 32,
  parameter int TDESTW   = 4,
  parameter int TIDW     = 2,
  parameter int OUT_DEST = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              AXIS_S_TVALID,
  output logic              AXIS_S_TREADY,
  input  logic [TDATAW-1:0] AXIS_S_TDATA,
  input  logic              AXIS_S_TLAST,
  input  logic [TDESTW-1:0] AXIS_S_TDEST,
  output logic              AXIS_M_TVALID,
  input  logic              AXIS_M_TREADY,
  output logic [TDATAW-1:0] AXIS_M_TDATA,
  output logic              AXIS_M_TLAST,
  output logic [TDESTW-1:0] AXIS_M_TDEST
);

  typedef enum logic [1:0] {WAIT_A, WAIT_B, SEND} state_t;

  state_t            state_q;
  logic [TDATAW-1:0] a_q, b_q, sum_q;
  logic              m_tvalid_q, m_tlast_q;
  logic              s_fire;

  // Ready depends only on state (and reset), never on the downstream ready.
  assign AXIS_S_TREADY = (state_q != SEND) && !RST;
  assign s_fire        = AXIS_S_TVALID && AXIS_S_TREADY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= WAIT_A;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
    end else begin
      case (state_q)
        WAIT_A: if (s_fire) begin
          a_q     <= AXIS_S_TDATA;
          state_q <= WAIT_B;
        end
        WAIT_B: if (s_fire) begin
          b_q        <= AXIS_S_TDATA;
          sum_q      <= a_q + AXIS_S_TDATA;  // carry out dropped
          m_tvalid_q <= 1'b1;
          m_tlast_q  <= 1'b1;
          state_q    <= SEND;
        end
        SEND: if (AXIS_M_TREADY) begin
          m_tvalid_q <= 1'b0;
          m_tlast_q  <= 1'b0;
          state_q    <= WAIT_A;
        end
        default: state_q <= WAIT_A;
      endcase
    end
  end

  assign AXIS_M_TVALID = m_tvalid_q;
  assign AXIS_M_TDATA  = sum_q;
  assign AXIS_M_TLAST  = m_tlast_q;
  assign AXIS_M_TDEST  = TDESTW'(OUT_DEST);

  // Routing/framing inputs and the stored B operand do not feed any output.
  logic [TIDW-1:0] unused_tid;
  logic            unused_in;
  assign unused_tid = '0;
  assign unused_in  = ^{AXIS_S_TLAST, AXIS_S_TDEST, b_q, unused_tid};

endmodule

// File: tb/tb_axis_pair_adder.sv
// Directed bench for axis_pair_adder: drives operand pairs and checks result beats.
module tb_axis_pair_adder;

  logic        CLK;
  logic        RST;
  logic        AXIS_S_TVALID;
  logic        AXIS_S_TREADY;
  logic [31:0] AXIS_S_TDATA;
  logic        AXIS_S_TLAST;
  logic [3:0]  AXIS_S_TDEST;
  logic        AXIS_M_TVALID;
  logic        AXIS_M_TREADY;
  logic [31:0] AXIS_M_TDATA;
  logic        AXIS_M_TLAST;
  logic [3:0]  AXIS_M_TDEST;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] q_data[$];
  logic        q_last[$];
  logic [3:0]  q_dest[$];

  axis_pair_adder dut (
    .CLK(CLK), .RST(RST),
    .AXIS_S_TVALID(AXIS_S_TVALID), .AXIS_S_TREADY(AXIS_S_TREADY),
    .AXIS_S_TDATA(AXIS_S_TDATA), .AXIS_S_TLAST(AXIS_S_TLAST),
    .AXIS_S_TDEST(AXIS_S_TDEST),
    .AXIS_M_TVALID(AXIS_M_TVALID), .AXIS_M_TREADY(AXIS_M_TREADY),
    .AXIS_M_TDATA(AXIS_M_TDATA), .AXIS_M_TLAST(AXIS_M_TLAST),
    .AXIS_M_TDEST(AXIS_M_TDEST)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Record every completed output transfer.
  always @(posedge CLK) begin
    if (!RST && AXIS_M_TVALID && AXIS_M_TREADY) begin
      q_data.push_back(AXIS_M_TDATA);
      q_last.push_back(AXIS_M_TLAST);
      q_dest.push_back(AXIS_M_TDEST);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic l, input logic [3:0] dst);
    bit done = 0;
    AXIS_S_TVALID = 1'b1;
    AXIS_S_TDATA  = d;
    AXIS_S_TLAST  = l;
    AXIS_S_TDEST  = dst;
    for (int i = 0; i < 20 && !done; i++) begin
      done = AXIS_S_TREADY;
      tick();
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
    AXIS_S_TVALID = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] exp);
    chk({tag, "_present"}, 32'(q_data.size() > 0), 32'd1);
    if (q_data.size() > 0) begin
      chk({tag, "_data"}, q_data.pop_front(), exp);
      chk({tag, "_last"}, 32'(q_last.pop_front()), 32'd1);
      chk({tag, "_dest"}, 32'(q_dest.pop_front()), 32'd3);
    end
  endtask

  initial begin
    int idx;
    int cyc;
    bit fire;
    RST = 1'b1;
    AXIS_S_TVALID = 1'b0;
    AXIS_S_TDATA  = '0;
    AXIS_S_TLAST  = 1'b0;
    AXIS_S_TDEST  = '0;
    AXIS_M_TREADY = 1'b1;

    // Reset state
    tick(); tick();
    chk("rst_mvalid", 32'(AXIS_M_TVALID), 32'd0);
    chk("rst_mdata",  AXIS_M_TDATA, 32'd0);
    chk("rst_mlast",  32'(AXIS_M_TLAST), 32'd0);
    chk("rst_mdest",  32'(AXIS_M_TDEST), 32'd3);
    chk("rst_sready", 32'(AXIS_S_TREADY), 32'd0);
    RST = 1'b0;
    #1;
    chk("idle_sready", 32'(AXIS_S_TREADY), 32'd1);

    // 5 + 7: valid the cycle after the B handshake, for exactly one cycle
    send(32'h5, 1'b0, 4'h0);
    chk("basic_a_novalid", 32'(AXIS_M_TVALID), 32'd0);
    send(32'h7, 1'b0, 4'h0);
    chk("basic_mvalid", 32'(AXIS_M_TVALID), 32'd1);
    chk("basic_mdata",  AXIS_M_TDATA, 32'hC);
    chk("basic_mlast",  32'(AXIS_M_TLAST), 32'd1);
    chk("basic_sready", 32'(AXIS_S_TREADY), 32'd0);
    tick();
    chk("basic_pulse_end", 32'(AXIS_M_TVALID), 32'd0);
    pop_chk("basic", 32'hC);

    // Overflow wraps
    send(32'hFFFF_FFFF, 1'b0, 4'h0);
    send(32'h2, 1'b0, 4'h0);
    chk("ovf_mdata", AXIS_M_TDATA, 32'h1);
    tick();
    pop_chk("ovf", 32'h1);

    // Backpressure; a waiting sender must not be consumed during SEND
    AXIS_M_TREADY = 1'b0;
    send(32'd10, 1'b0, 4'h0);
    send(32'd20, 1'b0, 4'h0);
    AXIS_S_TVALID = 1'b1;
    AXIS_S_TDATA  = 32'h99;
    for (int i = 0; i < 5; i++) begin
      chk("bp_mvalid", 32'(AXIS_M_TVALID), 32'd1);
      chk("bp_mdata",  AXIS_M_TDATA, 32'd30);
      chk("bp_sready", 32'(AXIS_S_TREADY), 32'd0);
      tick();
    end
    chk("bp_none_yet", 32'(q_data.size()), 32'd0);
    AXIS_S_TVALID = 1'b0;
    AXIS_M_TREADY = 1'b1;
    tick();
    chk("bp_released", 32'(AXIS_M_TVALID), 32'd0);
    chk("bp_count", 32'(q_data.size()), 32'd1);
    pop_chk("bp", 32'd30);

    // Continuous stream 0x10..0x19 with alternating TLAST
    idx = 0; cyc = 0;
    AXIS_S_TVALID = 1'b1;
    AXIS_S_TDATA  = 32'h10;
    AXIS_S_TLAST  = 1'b0;
    while (idx < 10 && cyc < 100) begin
      fire = AXIS_S_TREADY;
      tick();
      cyc++;
      if (fire) idx++;
      AXIS_S_TDATA = 32'h10 + 32'(idx);
      AXIS_S_TLAST = idx[0];
    end
    AXIS_S_TVALID = 1'b0;
    chk("stream_cycles", 32'(cyc), 32'd14);
    tick();
    chk("stream_count", 32'(q_data.size()), 32'd5);
    pop_chk("stream0", 32'h21);
    pop_chk("stream1", 32'h25);
    pop_chk("stream2", 32'h29);
    pop_chk("stream3", 32'h2D);
    pop_chk("stream4", 32'h31);

    // Reset mid-pair discards the half-collected operand
    send(32'h55, 1'b0, 4'h0);
    RST = 1'b1;
    tick();
    chk("midrst_sready", 32'(AXIS_S_TREADY), 32'd0);
    RST = 1'b0;
    #1;
    chk("midrst_mvalid", 32'(AXIS_M_TVALID), 32'd0);
    send(32'h1, 1'b0, 4'h0);
    chk("midrst_after_one", 32'(AXIS_M_TVALID), 32'd0);
    send(32'h2, 1'b0, 4'h0);
    chk("midrst_mdata", AXIS_M_TDATA, 32'h3);
    tick();
    chk("midrst_count", 32'(q_data.size()), 32'd1);
    pop_chk("midrst", 32'h3);

    // Input TDEST/TLAST do not influence output routing
    send(32'h4, 1'b1, 4'hA);
    send(32'h6, 1'b0, 4'h0);
    chk("dest_mdest", 32'(AXIS_M_TDEST), 32'd3);
    tick();
    pop_chk("dest", 32'hA);

    tick(); tick();
    chk("final_empty", 32'(q_data.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
